// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium keystream consumer: session states and
// the generator's fixed dimensions.
package trivium_pkg;

   localparam int TRIV_STATE_BITS = 288;
   localparam int TRIV_WARMUP     = 4 * 288;
   localparam int TRIV_KEY_BITS   = 80;
   localparam int TRIV_IV_BITS    = 80;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      WARM = 3'd2,
      RUN  = 3'd3,
      ERR  = 3'd4
   } state_t;

endpackage

// File: rtl/ks_word_fifo.sv
// Two-entry keystream word buffer. A push while full is accepted only when a pop
// frees the head slot in the same cycle. A pop while empty is ignored.
module ks_word_fifo #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   // NOTE: the storage array has no reset. An entry is only read after a push
   // has written it, so only the pointers and count need a reset.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/trivium_ks_xor.sv
// Consumes the serial Trivium keystream: loads the generator, discards the warm-up
// bits, packs keystream words LSB-first and XORs them onto plaintext words.
module trivium_ks_xor
   import trivium_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int WARMUP = TRIV_WARMUP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             ks_load,
   input  logic             ks_bit,
   input  logic             pt_valid,
   output logic             pt_ready,
   input  logic [WIDTH-1:0] pt_data,
   output logic             ct_valid,
   input  logic             ct_ready,
   output logic [WIDTH-1:0] ct_data,
   output logic             ks_run,
   output logic             ovf
);

   localparam int WC_W = $clog2(WARMUP + 1);
   localparam int PC_W = $clog2(WIDTH);

   state_t            state;
   state_t            nxt;
   logic [WC_W-1:0]   warm_cnt;
   logic [PC_W-1:0]   pack_cnt;
   logic [WIDTH-1:0]  pack_reg;
   logic [WIDTH-1:0]  word;
   logic [WIDTH-1:0]  head;
   logic              full;
   logic              empty;
   logic              warm_done;
   logic              word_done;
   logic              xfer;
   logic              pop;
   logic              overrun;

   assign ks_load   = (state == LOAD);
   assign ks_run    = (state == RUN);
   assign warm_done = (state == WARM) && (warm_cnt == WC_W'(WARMUP - 1));
   assign word_done = (state == RUN) && (pack_cnt == PC_W'(WIDTH - 1));
   assign word      = {ks_bit, pack_reg[WIDTH-1:1]};
   assign pt_ready  = (state == RUN) && !empty && (!ct_valid || ct_ready);
   assign xfer      = pt_valid && pt_ready;
   assign pop       = xfer && !start;
   assign overrun   = word_done && full && !pop && !start;

   ks_word_fifo #(.WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (start),
      .push  (word_done && !start),
      .pop   (pop),
      .din   (word),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   // NOTE: nxt is given a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = LOAD;
         LOAD:    nxt = WARM;
         WARM:    if (warm_done) nxt = RUN;
         RUN:     if (overrun) nxt = ERR;
         ERR:     nxt = ERR;
         default: nxt = IDLE;
      endcase
      if (start) nxt = LOAD;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         warm_cnt <= '0;
      end else begin
         state <= nxt;
         if (state == LOAD)      warm_cnt <= '0;
         else if (state == WARM) warm_cnt <= warm_cnt + WC_W'(1);
      end
   end

   // Shifting in at the top leaves the first sampled bit at bit 0 after WIDTH samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pack_cnt <= '0;
         pack_reg <= '0;
      end else if (start) begin
         pack_cnt <= '0;
      end else if (state == RUN) begin
         pack_reg <= word;
         pack_cnt <= word_done ? '0 : pack_cnt + PC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ct_valid <= 1'b0;
         ct_data  <= '0;
         ovf      <= 1'b0;
      end else begin
         if (start) begin
            ct_valid <= 1'b0;
         end else if (xfer) begin
            ct_valid <= 1'b1;
            ct_data  <= pt_data ^ head;
         end else if (ct_ready) begin
            ct_valid <= 1'b0;
         end

         if (start)        ovf <= 1'b0;
         else if (overrun) ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_trivium_ks_xor.sv
// Directed bench for trivium_ks_xor: reset, warm-up length, packing, XOR handshake,
// overrun, full-with-pop and mid-session restart.
module tb_trivium_ks_xor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       ks_load;
   logic       ks_bit;
   logic       pt_valid;
   logic       pt_ready;
   logic [7:0] pt_data;
   logic       ct_valid;
   logic       ct_ready;
   logic [7:0] ct_data;
   logic       ks_run;
   logic       ovf;

   int vectors = 0;
   int miscompares = 0;

   trivium_ks_xor #(.WIDTH(8), .WARMUP(1152)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .ks_load  (ks_load),
      .ks_bit   (ks_bit),
      .pt_valid (pt_valid),
      .pt_ready (pt_ready),
      .pt_data  (pt_data),
      .ct_valid (ct_valid),
      .ct_ready (ct_ready),
      .ct_data  (ct_data),
      .ks_run   (ks_run),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] w, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         ks_bit = w[i];
         step();
      end
   endtask

   // Caller raises start; this covers the load pulse and the 1152-bit warm-up.
   task automatic do_warmup(input string tag);
      int  n;
      bit  load_seen;
      step();
      check({tag, "_load_hi"}, ks_load, 1);
      check({tag, "_flush_cnt"}, dut.u_fifo.count, 0);
      check({tag, "_flush_ctv"}, ct_valid, 0);
      check({tag, "_flush_ovf"}, ovf, 0);
      start = 1'b0;
      step();
      check({tag, "_load_lo"}, ks_load, 0);
      n = 0;
      load_seen = 1'b0;
      while (!ks_run && n < 2000) begin
         ks_bit = 1'b1;
         step();
         if (ks_load) load_seen = 1'b1;
         n++;
      end
      check({tag, "_warm_len"}, n, 1152);
      check({tag, "_load_once"}, load_seen, 0);
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b1;
      ks_bit   = 1'b0;
      pt_valid = 1'b0;
      pt_data  = 8'h00;
      ct_ready = 1'b0;
      #12;
      check("rst_outs", {ks_load, pt_ready, ct_valid, ks_run, ovf}, 0);
      check("rst_ctdata", ct_data, 0);
      step();
      rst   = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("idle_outs", {ks_load, pt_ready, ks_run}, 0);

      // Session 1: packing, XOR, backpressure and overrun.
      start = 1'b1;
      do_warmup("s1");
      send_bits(8'hAA, 0, 6);
      check("s1_w1_pre_rdy", pt_ready, 0);
      check("s1_w1_pre_cnt", dut.u_fifo.count, 0);
      send_bits(8'hAA, 7, 7);
      check("s1_w1_rdy", pt_ready, 1);
      check("s1_w1_cnt", dut.u_fifo.count, 1);
      pt_data  = 8'h5A;
      pt_valid = 1'b1;
      ct_ready = 1'b1;
      send_bits(8'h3C, 0, 0);
      check("s1_xor_ctv", ct_valid, 1);
      check("s1_xor_data", ct_data, 8'hF0);
      check("s1_xor_cnt", dut.u_fifo.count, 0);
      pt_valid = 1'b0;
      send_bits(8'h3C, 1, 1);
      check("s1_ct_drain", ct_valid, 0);
      send_bits(8'h3C, 2, 7);
      check("s1_w2_cnt", dut.u_fifo.count, 1);
      ct_ready = 1'b0;
      pt_valid = 1'b1;
      pt_data  = 8'hFF;
      send_bits(8'h96, 0, 0);
      check("s1_bp_data", ct_data, 8'hC3);
      check("s1_bp_ctv", ct_valid, 1);
      check("s1_bp_rdy", pt_ready, 0);
      send_bits(8'h96, 1, 7);
      check("s1_w3_cnt", dut.u_fifo.count, 1);
      send_bits(8'h55, 0, 7);
      check("s1_full_cnt", dut.u_fifo.count, 2);
      check("s1_full_ovf", ovf, 0);
      send_bits(8'hE1, 0, 7);
      check("s1_err_ovf", ovf, 1);
      check("s1_err_run", ks_run, 0);
      check("s1_err_rdy", pt_ready, 0);
      check("s1_err_data", ct_data, 8'hC3);
      check("s1_err_ctv", ct_valid, 1);
      check("s1_err_cnt", dut.u_fifo.count, 2);
      send_bits(8'h0F, 0, 7);
      check("s1_err_hold", {ovf, ct_valid, ct_data}, {1'b1, 1'b1, 8'hC3});
      check("s1_err_nopack", dut.u_fifo.count, 2);

      // Session 2: restart from ERR, then full buffer with a coinciding pop.
      pt_valid = 1'b0;
      start    = 1'b1;
      do_warmup("s2");
      ct_ready = 1'b1;
      send_bits(8'hAA, 0, 7);
      send_bits(8'h3C, 0, 7);
      check("s2_full_cnt", dut.u_fifo.count, 2);
      send_bits(8'h96, 0, 6);
      pt_valid = 1'b1;
      pt_data  = 8'h00;
      send_bits(8'h96, 7, 7);
      check("s2_pp_cnt", dut.u_fifo.count, 2);
      check("s2_pp_ovf", ovf, 0);
      check("s2_pp_run", ks_run, 1);
      check("s2_pp_data", ct_data, 8'hAA);
      send_bits(8'h55, 0, 0);
      check("s2_pop_cnt", dut.u_fifo.count, 1);
      check("s2_pop_data", ct_data, 8'h3C);
      check("s2_pop_ctv", ct_valid, 1);
      pt_valid = 1'b0;

      // Session 3: restart mid-word during RUN with one buffered word.
      start = 1'b1;
      do_warmup("s3");
      send_bits(8'hAA, 0, 6);
      check("s3_pre_cnt", dut.u_fifo.count, 0);
      send_bits(8'hAA, 7, 7);
      check("s3_w1_cnt", dut.u_fifo.count, 1);
      pt_valid = 1'b1;
      pt_data  = 8'h0F;
      send_bits(8'h00, 0, 0);
      check("s3_xor_data", ct_data, 8'hA5);
      check("s3_xor_cnt", dut.u_fifo.count, 0);
      pt_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
